// File: rtl/apb_mr_cmd_sequencer.sv
// apb_mr_cmd_sequencer
// Mode-register command sequencer. It arbitrates the per-rank MRW/MRR request
// levels round-robin and issues one MR command at a time. It waits for tMRD
// after an MRW, or for read data after an MRR. It then returns a one-cycle,
// one-hot done pulse for the served rank and type.
// Optional feature: define MR_SEQ_TIMEOUT_EN to bound the MRR read-data wait
// to MRR_TIMEOUT cycles and enable the sticky mrr_err_o flag.
// All outputs are registered. An output changes one clock after the FSM
// decision that drives it.
module apb_mr_cmd_sequencer #(
  parameter int NB_RANK       = 8,
  parameter int MR_ADDR_WIDTH = 8,
  parameter int MR_DATA_WIDTH = 8,
  parameter int TMRD_CYC      = 4,
  parameter int MRR_TIMEOUT   = 64
) (
  input  logic                       pclk_i,
  input  logic                       prst_ni,
  input  logic [NB_RANK-1:0]         rank_mrw_i,
  input  logic [NB_RANK-1:0]         rank_mrr_i,
  input  logic [MR_ADDR_WIDTH-1:0]   mr_addr_i,
  input  logic [MR_DATA_WIDTH-1:0]   mr_wdata_i,
  output logic [NB_RANK-1:0]         mrw_done_status_o,
  output logic [NB_RANK-1:0]         mrr_done_status_o,
  output logic [MR_DATA_WIDTH-1:0]   mrr_rdata_o,
  output logic                       mrr_err_o,
  output logic                       busy_o,
  output logic                       cmd_valid_o,
  input  logic                       cmd_ready_i,
  output logic                       cmd_type_o,
  output logic [$clog2(NB_RANK)-1:0] cmd_rank_o,
  output logic [MR_ADDR_WIDTH-1:0]   cmd_addr_o,
  output logic [MR_DATA_WIDTH-1:0]   cmd_wdata_o,
  input  logic                       rd_valid_i,
  input  logic [MR_DATA_WIDTH-1:0]   rd_data_i
);

  localparam int RW   = $clog2(NB_RANK);
  localparam int CMAX = (TMRD_CYC > MRR_TIMEOUT) ? TMRD_CYC : MRR_TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_WAIT_MRD = 3'd2,
    S_WAIT_RD  = 3'd3,
    S_DONE     = 3'd4
  } state_e;

  state_e                   state_q, state_d;
  logic [RW-1:0]            last_q, last_d;
  logic [RW-1:0]            rank_q, rank_d;
  logic                     type_q, type_d;
  logic [MR_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [MR_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [MR_DATA_WIDTH-1:0] rbuf_q, rbuf_d;
  logic [MR_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [NB_RANK-1:0]       srv_mrw_q, srv_mrw_d;
  logic [NB_RANK-1:0]       srv_mrr_q, srv_mrr_d;
  logic [NB_RANK-1:0]       mrw_done_q, mrw_done_d;
  logic [NB_RANK-1:0]       mrr_done_q, mrr_done_d;
  logic                     cmd_valid_q, cmd_valid_d;
  logic                     busy_q, busy_d;
`ifdef MR_SEQ_TIMEOUT_EN
  logic                     to_q, to_d;
  logic                     err_q, err_d;
`endif

  logic [NB_RANK-1:0]       pend_s;
  logic [NB_RANK-1:0]       onehot_s;
  logic                     grant_found_s;
  logic [RW-1:0]            grant_rank_s;
  logic                     grant_mrw_s;
  int                       idx_s;

  // A request is pending until its done pulse. It then stays blocked until the slave drops the level.
  assign pend_s   = (rank_mrw_i & ~srv_mrw_q) | (rank_mrr_i & ~srv_mrr_q);
  assign onehot_s = {{(NB_RANK-1){1'b0}}, 1'b1} << rank_q;

  // Round-robin search starting at the rank after the last grant, wrapping at NB_RANK.
  always_comb begin
    grant_found_s = 1'b0;
    grant_rank_s  = '0;
    idx_s         = 0;
    for (int i = 1; i <= NB_RANK; i++) begin
      idx_s = int'(last_q) + i;
      if (idx_s >= NB_RANK) begin
        idx_s = idx_s - NB_RANK;
      end else begin
        idx_s = idx_s;
      end
      if (!grant_found_s && pend_s[RW'(idx_s)]) begin
        grant_found_s = 1'b1;
        grant_rank_s  = RW'(idx_s);
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Within the granted rank an outstanding MRW is served before an MRR.
  assign grant_mrw_s = rank_mrw_i[grant_rank_s] & ~srv_mrw_q[grant_rank_s];

  // State and output registers; reset returns everything to idle with rank 0 first in line.
  always_ff @(posedge pclk_i or negedge prst_ni) begin
    if (!prst_ni) begin
      state_q     <= S_IDLE;
      last_q      <= RW'(NB_RANK - 1);
      rank_q      <= '0;
      type_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      rbuf_q      <= '0;
      rdata_q     <= '0;
      srv_mrw_q   <= '0;
      srv_mrr_q   <= '0;
      mrw_done_q  <= '0;
      mrr_done_q  <= '0;
      cmd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MR_SEQ_TIMEOUT_EN
      to_q        <= 1'b0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      rank_q      <= rank_d;
      type_q      <= type_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      rbuf_q      <= rbuf_d;
      rdata_q     <= rdata_d;
      srv_mrw_q   <= srv_mrw_d;
      srv_mrr_q   <= srv_mrr_d;
      mrw_done_q  <= mrw_done_d;
      mrr_done_q  <= mrr_done_d;
      cmd_valid_q <= cmd_valid_d;
      busy_q      <= busy_d;
`ifdef MR_SEQ_TIMEOUT_EN
      to_q        <= to_d;
      err_q       <= err_d;
`endif
    end
  end

  // Next-state and next-output logic of the command FSM.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    rank_d      = rank_q;
    type_d      = type_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    rbuf_d      = rbuf_q;
    rdata_d     = rdata_q;
    srv_mrw_d   = srv_mrw_q & rank_mrw_i;
    srv_mrr_d   = srv_mrr_q & rank_mrr_i;
    mrw_done_d  = '0;
    mrr_done_d  = '0;
    cmd_valid_d = 1'b0;
`ifdef MR_SEQ_TIMEOUT_EN
    to_d        = to_q;
    err_d       = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (grant_found_s) begin
          rank_d  = grant_rank_s;
          type_d  = ~grant_mrw_s;
          addr_d  = mr_addr_i;
          wdata_d = grant_mrw_s ? mr_wdata_i : '0;
          last_d  = grant_rank_s;
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (cmd_valid_q && cmd_ready_i) begin
          if (!type_q) begin
            cnt_d   = CW'(TMRD_CYC - 1);
            state_d = S_WAIT_MRD;
          end else begin
            cnt_d   = '0;
`ifdef MR_SEQ_TIMEOUT_EN
            to_d    = 1'b0;
            err_d   = 1'b0;
`endif
            state_d = S_WAIT_RD;
          end
        end else begin
          cmd_valid_d = 1'b1;
        end
      end
      S_WAIT_MRD: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_WAIT_RD: begin
        // Data on the timeout edge wins: it is checked first.
        if (rd_valid_i) begin
          rbuf_d  = rd_data_i;
          state_d = S_DONE;
        end else begin
`ifdef MR_SEQ_TIMEOUT_EN
          // The done pulse lands MRR_TIMEOUT cycles after the handshake.
          if (cnt_q == CW'(MRR_TIMEOUT - 2)) begin
            to_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
`else
          state_d = S_WAIT_RD;
`endif
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
        if (!type_q) begin
          mrw_done_d = onehot_s;
          srv_mrw_d  = (srv_mrw_q | onehot_s) & rank_mrw_i;
        end else begin
          mrr_done_d = onehot_s;
          srv_mrr_d  = (srv_mrr_q | onehot_s) & rank_mrr_i;
`ifdef MR_SEQ_TIMEOUT_EN
          if (to_q) begin
            err_d = 1'b1;
          end else begin
            rdata_d = rbuf_q;
          end
`else
          rdata_d = rbuf_q;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  assign mrw_done_status_o = mrw_done_q;
  assign mrr_done_status_o = mrr_done_q;
  assign mrr_rdata_o       = rdata_q;
  assign busy_o            = busy_q;
  assign cmd_valid_o       = cmd_valid_q;
  assign cmd_type_o        = type_q;
  assign cmd_rank_o        = rank_q;
  assign cmd_addr_o        = addr_q;
  assign cmd_wdata_o       = wdata_q;
`ifdef MR_SEQ_TIMEOUT_EN
  assign mrr_err_o         = err_q;
`else
  assign mrr_err_o         = 1'b0;
`endif

endmodule

// File: tb/tb_apb_mr_cmd_sequencer.sv
// Bench for apb_mr_cmd_sequencer: a per-cycle vector table for MRW and MRR
// flows, plus hand sequences for round-robin order, reset mid-operation and
// the MRR wait (timeout when MR_SEQ_TIMEOUT_EN is defined).
module tb_apb_mr_cmd_sequencer;

  localparam int TMRD = 4;
  localparam int TOUT = 64;

  logic       clk = 1'b0;
  logic       prst_ni;
  logic [7:0] rank_mrw, rank_mrr, mr_addr, mr_wdata, rd_data;
  logic       cmd_ready, rd_valid;
  logic [7:0] mrw_done, mrr_done, mrr_rdata, cmd_addr, cmd_wdata;
  logic       mrr_err, busy, cmd_valid, cmd_type;
  logic [2:0] cmd_rank;

  int total = 0;
  int bad   = 0;

  apb_mr_cmd_sequencer #(
    .NB_RANK(8), .MR_ADDR_WIDTH(8), .MR_DATA_WIDTH(8),
    .TMRD_CYC(TMRD), .MRR_TIMEOUT(TOUT)
  ) dut (
    .pclk_i(clk), .prst_ni(prst_ni),
    .rank_mrw_i(rank_mrw), .rank_mrr_i(rank_mrr),
    .mr_addr_i(mr_addr), .mr_wdata_i(mr_wdata),
    .mrw_done_status_o(mrw_done), .mrr_done_status_o(mrr_done),
    .mrr_rdata_o(mrr_rdata), .mrr_err_o(mrr_err), .busy_o(busy),
    .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready),
    .cmd_type_o(cmd_type), .cmd_rank_o(cmd_rank),
    .cmd_addr_o(cmd_addr), .cmd_wdata_o(cmd_wdata),
    .rd_valid_i(rd_valid), .rd_data_i(rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] mrw, mrr, addr, wdata;
    logic       ready, rdv;
    logic [7:0] rdd;
    logic       e_valid, e_type;
    logic [2:0] e_rank;
    logic [7:0] e_addr, e_wdata, e_mrwd, e_mrrd;
    logic       e_busy;
    logic [7:0] e_rdata;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [7:0] mrw, mrr, addr, wdata, input logic ready, rdv,
                     input logic [7:0] rdd, input logic ev, et, input logic [2:0] er,
                     input logic [7:0] ea, ew, emw, emr, input logic eb, input logic [7:0] erd);
    vec_t v;
    v.mrw = mrw; v.mrr = mrr; v.addr = addr; v.wdata = wdata;
    v.ready = ready; v.rdv = rdv; v.rdd = rdd;
    v.e_valid = ev; v.e_type = et; v.e_rank = er; v.e_addr = ea; v.e_wdata = ew;
    v.e_mrwd = emw; v.e_mrrd = emr; v.e_busy = eb; v.e_rdata = erd;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] obs();
    return {17'd0, cmd_valid, cmd_type, cmd_rank, cmd_addr, cmd_wdata,
            mrw_done, mrr_done, busy, mrr_err, mrr_rdata};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rank_mrw = 8'h00; rank_mrr = 8'h00; mr_addr = 8'h00; mr_wdata = 8'h00;
    cmd_ready = 1'b0; rd_valid = 1'b0; rd_data = 8'h00;
  endtask

  task automatic do_reset();
    idle_inputs();
    prst_ni = 1'b0;
    tick();
    prst_ni = 1'b1;
  endtask

  task automatic wait_valid(input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 30 && !ok; c++) begin
      if (cmd_valid) ok = 1'b1;
      else tick();
    end
    chk({name, "_valid_seen"}, {63'd0, ok}, 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] got [3];
    int         ng, n;
    bit         early, seen, dok, flag;
    logic [2:0] vr;

    idle_inputs();
    prst_ni = 1'b0;
    repeat (3) tick();
    chk("reset_state", obs(), 64'd0);
    prst_ni = 1'b1;

    // ---- vector table: single MRW, then MRR with backpressure ----
    //   mrw    mrr    addr   wdata  rdy rdv rdd     v  t  rk    addr   wd     mrwd   mrrd  busy rdata
    add(8'h04, 8'h00, 8'h03, 8'h01, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd2, 8'h03, 8'h01, 8'h00, 8'h00, 1'b1, 8'h00);
    add(8'h04, 8'h00, 8'h03, 8'h01, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd2, 8'h03, 8'h01, 8'h00, 8'h00, 1'b1, 8'h00);
    for (int i = 0; i < 5; i++)
      add(8'h04, 8'h00, 8'h03, 8'h01, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd2, 8'h03, 8'h01, 8'h00, 8'h00, 1'b1, 8'h00);
    add(8'h04, 8'h00, 8'h03, 8'h01, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd2, 8'h03, 8'h01, 8'h04, 8'h00, 1'b0, 8'h00);
    for (int i = 0; i < 2; i++)
      add(8'h04, 8'h00, 8'h03, 8'h01, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd2, 8'h03, 8'h01, 8'h00, 8'h00, 1'b0, 8'h00);
    add(8'h00, 8'h01, 8'h10, 8'h55, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 8'h10, 8'h00, 8'h00, 8'h00, 1'b1, 8'h00);
    for (int i = 0; i < 4; i++)
      add(8'h00, 8'h01, 8'h22, 8'h55, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 3'd0, 8'h10, 8'h00, 8'h00, 8'h00, 1'b1, 8'h00);
    add(8'h00, 8'h01, 8'h22, 8'h55, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 8'h10, 8'h00, 8'h00, 8'h00, 1'b1, 8'h00);
    add(8'h00, 8'h01, 8'h22, 8'h55, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 8'h10, 8'h00, 8'h00, 8'h00, 1'b1, 8'h00);
    add(8'h00, 8'h01, 8'h22, 8'h55, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 3'd0, 8'h10, 8'h00, 8'h00, 8'h00, 1'b1, 8'h00);
    add(8'h00, 8'h01, 8'h22, 8'h55, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b1, 3'd0, 8'h10, 8'h00, 8'h00, 8'h01, 1'b0, 8'hA5);
    add(8'h00, 8'h01, 8'h22, 8'h55, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 8'h10, 8'h00, 8'h00, 8'h00, 1'b0, 8'hA5);
    add(8'h00, 8'h00, 8'h22, 8'h55, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 3'd0, 8'h10, 8'h00, 8'h00, 8'h00, 1'b0, 8'hA5);

    for (int i = 0; i < vq.size(); i++) begin
      rank_mrw = vq[i].mrw; rank_mrr = vq[i].mrr; mr_addr = vq[i].addr; mr_wdata = vq[i].wdata;
      cmd_ready = vq[i].ready; rd_valid = vq[i].rdv; rd_data = vq[i].rdd;
      tick();
      chk($sformatf("vec%0d", i), obs(),
          {17'd0, vq[i].e_valid, vq[i].e_type, vq[i].e_rank, vq[i].e_addr, vq[i].e_wdata,
           vq[i].e_mrwd, vq[i].e_mrrd, vq[i].e_busy, 1'b0, vq[i].e_rdata});
    end

    // ---- round-robin with MRW-over-MRR priority ----
    do_reset();
    rank_mrw = 8'h81; rank_mrr = 8'h01; cmd_ready = 1'b1; rd_valid = 1'b1; rd_data = 8'h3C;
    ng = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (cmd_valid) begin
        if (ng < 3) got[ng] = {cmd_type, cmd_rank};
        ng++;
      end
    end
    chk("rr_count", 64'(ng), 64'd3);
    chk("rr_grant0", {60'd0, got[0]}, {60'd0, 4'b0_000});
    chk("rr_grant1", {60'd0, got[1]}, {60'd0, 4'b0_111});
    chk("rr_grant2", {60'd0, got[2]}, {60'd0, 4'b1_000});
    chk("rr_rdata", {56'd0, mrr_rdata}, 64'h3C);

    // ---- reset during WAIT_MRD ----
    do_reset();
    rank_mrw = 8'h02; cmd_ready = 1'b1;
    wait_valid("rstmid");
    tick();
    tick();
    prst_ni = 1'b0;
    #1;
    chk("rstmid_outputs", obs(), 64'd0);
    tick();
    prst_ni = 1'b1;
    early = 1'b0; seen = 1'b0; dok = 1'b0; vr = 3'd0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (mrw_done != 8'h00 && !seen) early = 1'b1;
      if (seen && mrw_done == 8'h02) dok = 1'b1;
      if (cmd_valid && !seen) begin
        seen = 1'b1;
        vr   = cmd_rank;
      end
    end
    chk("rstmid_no_done", {63'd0, early}, 64'd0);
    chk("rstmid_reissue", {60'd0, seen, vr}, {60'd0, 1'b1, 3'd1});
    chk("rstmid_done", {63'd0, dok}, 64'd1);

`ifdef MR_SEQ_TIMEOUT_EN
    // ---- MRR timeout, then data exactly on the timeout edge ----
    do_reset();
    rank_mrr = 8'h08; cmd_ready = 1'b1;
    wait_valid("to1");
    n = 0;
    for (int c = 0; c < 200; c++) begin
      tick();
      n++;
      if (mrr_done != 8'h00) break;
    end
    chk("to1_latency", 64'(n), 64'(TOUT + 1));
    chk("to1_done", {56'd0, mrr_done}, 64'h08);
    chk("to1_err", {63'd0, mrr_err}, 64'd1);
    chk("to1_rdata_held", {56'd0, mrr_rdata}, 64'h00);
    rank_mrr = 8'h00;
    tick();
    tick();
    rank_mrr = 8'h08;
    wait_valid("to2");
    chk("to2_err_before", {63'd0, mrr_err}, 64'd1);
    tick();
    n = 1;
    chk("to2_err_cleared", {63'd0, mrr_err}, 64'd0);
    while (n < TOUT - 1) begin
      tick();
      n++;
    end
    rd_valid = 1'b1; rd_data = 8'hC3;
    tick();
    rd_valid = 1'b0;
    tick();
    chk("to2_done", {56'd0, mrr_done}, 64'h08);
    chk("to2_err", {63'd0, mrr_err}, 64'd0);
    chk("to2_rdata", {56'd0, mrr_rdata}, 64'hC3);
`else
    // ---- without timeout the MRR waits for data indefinitely ----
    do_reset();
    rank_mrr = 8'h08; cmd_ready = 1'b1;
    wait_valid("nto");
    tick();
    flag = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (mrr_done != 8'h00 || !busy || mrr_err) flag = 1'b1;
    end
    chk("nto_still_waiting", {63'd0, flag}, 64'd0);
    rd_valid = 1'b1; rd_data = 8'h99;
    tick();
    rd_valid = 1'b0;
    tick();
    chk("nto_done", {56'd0, mrr_done}, 64'h08);
    chk("nto_rdata", {56'd0, mrr_rdata}, 64'h99);
    chk("nto_err", {63'd0, mrr_err}, 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
